fetch_queue_stage: RTL and testbench
====================================

// Module: fetch_queue_stage
// PURPOSE
//  Next-generation fetch back end. Takes one FETCH_WIDTH fetch group per cycle from the i-cache read path.
//  Squashes the lanes that follow the first predicted-taken branch and compacts the surviving lanes.
//  Buffers them in a QUEUE_DEPTH circular instruction queue that decouples fetch from pre-decode.
//  Drains up to DECODE_WIDTH instructions per cycle into pre-decode.
// PARAMETERS
//  FETCH_WIDTH   4    lanes per incoming fetch group
//  DECODE_WIDTH  2    max lanes dequeued per cycle
//  QUEUE_DEPTH   8    entries; power of two, >= max(FETCH_WIDTH, DECODE_WIDTH)
//  PC_WIDTH      32   PC bits
//  INSN_WIDTH    32   instruction bits
//  INSN_BYTES    4    PC increment per instruction
// PORTS
//  clk             in   1                      clock
//  rst             in   1                      synchronous reset, active-low (0 = reset)
//  flush           in   1                      pipeline clear (redirect from back end)
//  in_valid        in   1                      fetch group present
//  in_ready        out  1                      group will be accepted this cycle
//  in_lane_valid   in   FETCH_WIDTH            per-lane valid (any pattern)
//  in_pc           in   FETCH_WIDTH*PC_WIDTH   per-lane PC
//  in_insn         in   FETCH_WIDTH*INSN_WIDTH per-lane instruction word
//  in_pred_taken   in   FETCH_WIDTH            per-lane branch predicted taken
//  in_pred_target  in   FETCH_WIDTH*PC_WIDTH   per-lane BTB target
//  out_valid       out  DECODE_WIDTH           valid lanes; always contiguous from lane 0
//  out_pc          out  DECODE_WIDTH*PC_WIDTH  head-entry PCs
//  out_insn        out  DECODE_WIDTH*INSN_WIDTH head-entry instructions
//  out_pred_taken  out  DECODE_WIDTH           predicted taken
//  out_pred_addr   out  DECODE_WIDTH*PC_WIDTH  predicted next PC
//  out_take        in   clog2(DECODE_WIDTH+1)  lanes consumed by pre-decode this cycle
//  redirect_valid  out  1                      registered; fetch must resteer
//  redirect_pc     out  PC_WIDTH               resteer target
//  count           out  clog2(QUEUE_DEPTH+1)   occupied entries
//  perf_stall_begin out 1                      first cycle of an input back-pressure stall
// BEHAVIOUR
//  - Reset (rst==0 at posedge): head/tail/count=0, redirect_valid=0, redirect_pc=0, perf state cleared.
//    Resulting outputs: out_valid=0, in_ready=1. Reset overrides flush and every other input.
//  - in_ready = (QUEUE_DEPTH - count) >= FETCH_WIDTH, using the registered count.
//    Same-cycle dequeue does not raise in_ready.
//  - accept = in_valid & in_ready & !flush.
//  - Squash: find lowest lane i with in_lane_valid[i] & in_pred_taken[i]; drop every lane j>i.
//  - Compaction: surviving valid lanes are written in lane order to tail..tail+n_in-1 (mod DEPTH).
//  - A group with no valid lanes is accepted with n_in=0.
//  - Entry fields: pc, insn, pred_taken, pred_addr.
//    pred_addr = pred_taken ? target : pc+INSN_BYTES, wrapping mod 2^PC_WIDTH.
//  - Redirect: the cycle after an accepted group with a taken lane, redirect_valid=1 and redirect_pc=that target.
//    Otherwise redirect_valid=0. It is a one-cycle pulse.
//  - Output is first-word fall-through: out lane k shows entry head+k when k<count, else out_valid[k]=0.
//    Fields of invalid lanes are 0. An enqueued entry is visible at the output 1 cycle after acceptance.
//  - Dequeue: n_out = min(out_take, count, DECODE_WIDTH); head += n_out (mod DEPTH).
//    An out_take beyond valid lanes is clipped, not an error.
//  - Simultaneous push and pop: count' = count + n_in - n_out. Pointers wrap naturally (log2 DEPTH bits).
//  - flush: next cycle head=tail=count=0 and redirect_valid=0. The same-cycle input and out_take are ignored.
//  - perf_stall_begin = in_valid & !in_ready & !stall_q.
//    stall_q is registered (in_valid & !in_ready); it is cleared by reset and by flush.
// STRUCTURE
//  - Package FetchQueueTypes holds:
//    FetchQueueEntry struct {pc, insn, pred_taken, pred_addr};
//    FetchQueueIndexPath / FetchQueueCountPath typedefs;
//    constants FETCH_QUEUE_DEPTH and INSN_BYTE_WIDTH.
//  - One sub-module, fetch_lane_compactor (combinational):
//    squash mask, prefix-sum write slots, n_in, taken flag and target.
//  - Top level holds the entry array, pointers, count, redirect register and perf logic.
// TESTING (FETCH_WIDTH=4, DECODE_WIDTH=2, QUEUE_DEPTH=8)
//  1 Reset: rst=0 for 2 cycles with in_valid=1 -> count=0, out_valid=00, in_ready=1, redirect_valid=0.
//  2 Straight line: pc 0x100..0x10C, mask 1111, no taken, out_take=0 -> next cycle count=4.
//    Outputs: out_pc 0x100/0x104, out_pred_addr 0x104/0x108.
//  3 Taken lane 1, target 0x200, mask 1111 -> count=2 (0x100, 0x104).
//    Next cycle redirect_valid=1 and redirect_pc=0x200, then 0 the cycle after.
//  4 Sparse mask 1010 (lanes 1 and 3) -> entries 0x104, 0x10C at out lanes 0 and 1. count=2.
//  5 count=6, in_valid=1, out_take=2 -> in_ready=0 and perf_stall_begin=1 that cycle.
//    Next cycle count=4, in_ready=1, group accepted, count=8 the following cycle.
//    Continue pushing/popping until tail wraps, and check FIFO order.
//  6 Flush with in_valid=1, out_take=2, count=5 -> next cycle count=0, out_valid=00, nothing enqueued.

Source files
------------

// File: rtl/fetch_queue_stage_pkg.sv
// Shared types and constants for the fetch queue stage: entry layout,
// pointer/count widths and the default geometry.
package FetchQueueTypes;

  localparam int FETCH_QUEUE_DEPTH = 8;
  localparam int INSN_BYTE_WIDTH   = 4;
  localparam int FQ_PC_WIDTH       = 32;
  localparam int FQ_INSN_WIDTH     = 32;

  typedef logic [$clog2(FETCH_QUEUE_DEPTH)-1:0]   FetchQueueIndexPath;
  typedef logic [$clog2(FETCH_QUEUE_DEPTH+1)-1:0] FetchQueueCountPath;

  typedef struct packed {
    logic [FQ_PC_WIDTH-1:0]   pc;
    logic [FQ_INSN_WIDTH-1:0] insn;
    logic                     pred_taken;
    logic [FQ_PC_WIDTH-1:0]   pred_addr;
  } FetchQueueEntry;

endpackage

// File: rtl/fetch_queue_stage_compactor.sv
// Squashes lanes after the first predicted-taken valid lane and assigns each
// surviving lane a dense write slot relative to the queue tail.
module fetch_lane_compactor
  import FetchQueueTypes::*;
#(
  parameter int FETCH_WIDTH = 4,
  parameter int PC_WIDTH    = FQ_PC_WIDTH
) (
  input  logic [FETCH_WIDTH-1:0]                      lane_valid_i,
  input  logic [FETCH_WIDTH-1:0]                      pred_taken_i,
  input  logic [FETCH_WIDTH*PC_WIDTH-1:0]             pred_target_i,
  output logic [FETCH_WIDTH-1:0]                      keep_o,
  output logic [FETCH_WIDTH*$clog2(FETCH_WIDTH)-1:0]  slot_o,
  output logic [$clog2(FETCH_WIDTH+1)-1:0]            n_in_o,
  output logic                                        taken_o,
  output logic [PC_WIDTH-1:0]                         target_o
);

  localparam int SLOT_W = $clog2(FETCH_WIDTH);
  localparam int NIN_W  = $clog2(FETCH_WIDTH+1);

  logic [NIN_W-1:0] cnt;

  // Once a taken lane is kept, taken_o blocks every later lane.
  always_comb begin
    keep_o   = '0;
    slot_o   = '0;
    taken_o  = 1'b0;
    target_o = '0;
    cnt      = '0;
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      slot_o[i*SLOT_W +: SLOT_W] = cnt[SLOT_W-1:0];
      if (lane_valid_i[i] && !taken_o) begin
        keep_o[i] = 1'b1;
        cnt       = cnt + NIN_W'(1);
        taken_o   = pred_taken_i[i];
        target_o  = pred_taken_i[i] ? pred_target_i[i*PC_WIDTH +: PC_WIDTH] : target_o;
      end else begin
        keep_o[i] = 1'b0;
      end
    end
    n_in_o = cnt;
  end

endmodule

// File: rtl/fetch_queue_stage.sv
// Fetch back end: squash/compact an incoming fetch group into a circular
// instruction queue and present up to DECODE_WIDTH head entries to pre-decode.
module fetch_queue_stage
  import FetchQueueTypes::*;
#(
  parameter int FETCH_WIDTH  = 4,
  parameter int DECODE_WIDTH = 2,
  parameter int QUEUE_DEPTH  = FETCH_QUEUE_DEPTH,
  parameter int PC_WIDTH     = FQ_PC_WIDTH,
  parameter int INSN_WIDTH   = FQ_INSN_WIDTH,
  parameter int INSN_BYTES   = INSN_BYTE_WIDTH
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                flush,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [FETCH_WIDTH-1:0]              in_lane_valid,
  input  logic [FETCH_WIDTH*PC_WIDTH-1:0]     in_pc,
  input  logic [FETCH_WIDTH*INSN_WIDTH-1:0]   in_insn,
  input  logic [FETCH_WIDTH-1:0]              in_pred_taken,
  input  logic [FETCH_WIDTH*PC_WIDTH-1:0]     in_pred_target,
  output logic [DECODE_WIDTH-1:0]             out_valid,
  output logic [DECODE_WIDTH*PC_WIDTH-1:0]    out_pc,
  output logic [DECODE_WIDTH*INSN_WIDTH-1:0]  out_insn,
  output logic [DECODE_WIDTH-1:0]             out_pred_taken,
  output logic [DECODE_WIDTH*PC_WIDTH-1:0]    out_pred_addr,
  input  logic [$clog2(DECODE_WIDTH+1)-1:0]   out_take,
  output logic                                redirect_valid,
  output logic [PC_WIDTH-1:0]                 redirect_pc,
  output logic [$clog2(QUEUE_DEPTH+1)-1:0]    count,
  output logic                                perf_stall_begin
);

  localparam int IDX_W  = $clog2(QUEUE_DEPTH);
  localparam int CNT_W  = $clog2(QUEUE_DEPTH+1);
  localparam int NIN_W  = $clog2(FETCH_WIDTH+1);
  localparam int SLOT_W = $clog2(FETCH_WIDTH);

  function automatic logic [CNT_W-1:0] min_cnt(input logic [CNT_W-1:0] a, input logic [CNT_W-1:0] b);
    return (a < b) ? a : b;
  endfunction

  FetchQueueEntry                   entry_q [QUEUE_DEPTH];
  FetchQueueEntry                   lane_entry [FETCH_WIDTH];
  logic [IDX_W-1:0]                 head_q, tail_q;
  logic [CNT_W-1:0]                 count_q, n_out, n_in_acc;
  logic                             redirect_valid_q, stall_q, accept;
  logic [PC_WIDTH-1:0]              redirect_pc_q;
  logic [FETCH_WIDTH-1:0]           keep;
  logic [FETCH_WIDTH*SLOT_W-1:0]    slot;
  logic [NIN_W-1:0]                 n_in;
  logic                             grp_taken;
  logic [PC_WIDTH-1:0]              grp_target;

  fetch_lane_compactor #(
    .FETCH_WIDTH (FETCH_WIDTH),
    .PC_WIDTH    (PC_WIDTH)
  ) u_compactor (
    .lane_valid_i  (in_lane_valid),
    .pred_taken_i  (in_pred_taken),
    .pred_target_i (in_pred_target),
    .keep_o        (keep),
    .slot_o        (slot),
    .n_in_o        (n_in),
    .taken_o       (grp_taken),
    .target_o      (grp_target)
  );

  assign in_ready         = (CNT_W'(QUEUE_DEPTH) - count_q) >= CNT_W'(FETCH_WIDTH);
  assign accept           = in_valid & in_ready & ~flush;
  assign n_in_acc         = accept ? CNT_W'(n_in) : CNT_W'(0);
  assign n_out            = min_cnt(min_cnt(CNT_W'(out_take), count_q), CNT_W'(DECODE_WIDTH));
  assign perf_stall_begin = in_valid & ~in_ready & ~stall_q;
  assign count            = count_q;
  assign redirect_valid   = redirect_valid_q;
  assign redirect_pc      = redirect_pc_q;

  // Per-lane entry image, including the predicted next PC.
  always_comb begin
    for (int l = 0; l < FETCH_WIDTH; l++) begin
      lane_entry[l].pc         = in_pc[l*PC_WIDTH +: PC_WIDTH];
      lane_entry[l].insn       = in_insn[l*INSN_WIDTH +: INSN_WIDTH];
      lane_entry[l].pred_taken = in_pred_taken[l];
      lane_entry[l].pred_addr  = in_pred_taken[l] ? in_pred_target[l*PC_WIDTH +: PC_WIDTH]
                                                  : in_pc[l*PC_WIDTH +: PC_WIDTH] + PC_WIDTH'(INSN_BYTES);
    end
  end

  // Pointer, occupancy, redirect and stall-tracking state.
  always_ff @(posedge clk) begin
    if (!rst) begin
      head_q           <= '0;
      tail_q           <= '0;
      count_q          <= '0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
      stall_q          <= 1'b0;
    end else if (flush) begin
      head_q           <= '0;
      tail_q           <= '0;
      count_q          <= '0;
      redirect_valid_q <= 1'b0;
      stall_q          <= 1'b0;
    end else begin
      head_q           <= head_q + IDX_W'(n_out);
      tail_q           <= tail_q + IDX_W'(n_in_acc);
      count_q          <= count_q + n_in_acc - n_out;
      redirect_valid_q <= accept & grp_taken;
      if (accept && grp_taken) begin
        redirect_pc_q <= grp_target;
      end else begin
        redirect_pc_q <= redirect_pc_q;
      end
      stall_q          <= in_valid & ~in_ready;
    end
  end

  // Entry storage: kept lanes land densely from the tail.
  always_ff @(posedge clk) begin
    for (int l = 0; l < FETCH_WIDTH; l++) begin
      if (rst && accept && keep[l]) begin
        entry_q[tail_q + IDX_W'(slot[l*SLOT_W +: SLOT_W])] <= lane_entry[l];
      end
    end
  end

  // First-word fall-through view of the head; lanes beyond count read as zero.
  always_comb begin
    out_valid      = '0;
    out_pc         = '0;
    out_insn       = '0;
    out_pred_taken = '0;
    out_pred_addr  = '0;
    for (int k = 0; k < DECODE_WIDTH; k++) begin
      if (CNT_W'(k) < count_q) begin
        out_valid[k]                       = 1'b1;
        out_pc[k*PC_WIDTH +: PC_WIDTH]     = entry_q[head_q + IDX_W'(k)].pc;
        out_insn[k*INSN_WIDTH +: INSN_WIDTH] = entry_q[head_q + IDX_W'(k)].insn;
        out_pred_taken[k]                  = entry_q[head_q + IDX_W'(k)].pred_taken;
        out_pred_addr[k*PC_WIDTH +: PC_WIDTH] = entry_q[head_q + IDX_W'(k)].pred_addr;
      end else begin
        out_valid[k] = 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fetch_queue_stage.sv
// Scoreboard bench for fetch_queue_stage: a queue-based reference model is fed
// on acceptance and a negedge monitor compares the head view every cycle.
module tb_fetch_queue_stage;

  localparam int FW = 4;
  localparam int DW = 2;
  localparam int QD = 8;

  logic         clk = 1'b0;
  logic         rst, flush, in_valid, in_ready;
  logic [3:0]   in_lane_valid, in_pred_taken;
  logic [127:0] in_pc, in_insn, in_pred_target;
  logic [1:0]   out_valid, out_pred_taken, out_take;
  logic [63:0]  out_pc, out_insn, out_pred_addr;
  logic         redirect_valid, perf_stall_begin;
  logic [31:0]  redirect_pc;
  logic [3:0]   count;

  always #5 clk = ~clk;

  fetch_queue_stage dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_lane_valid(in_lane_valid), .in_pc(in_pc), .in_insn(in_insn),
    .in_pred_taken(in_pred_taken), .in_pred_target(in_pred_target),
    .out_valid(out_valid), .out_pc(out_pc), .out_insn(out_insn),
    .out_pred_taken(out_pred_taken), .out_pred_addr(out_pred_addr), .out_take(out_take),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .count(count),
    .perf_stall_begin(perf_stall_begin)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] insn;
    logic        pt;
    logic [31:0] pa;
  } ent_t;

  ent_t        sb[$];
  ent_t        pend[$];
  bit          pend_taken = 1'b0;
  logic [31:0] pend_tgt = 32'd0;
  bit          exp_rv = 1'b0;
  logic [31:0] exp_rpc = 32'd0;
  bit          stall_m = 1'b0;
  bit          chk_en = 1'b0;
  int          errors = 0;
  int          checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: keep valid lanes in order up to and including the first taken one.
  task automatic predict();
    pend.delete();
    pend_taken = 1'b0;
    if (rst && !flush && in_valid && (QD - sb.size()) >= FW) begin
      for (int i = 0; i < FW; i++) begin
        if (in_lane_valid[i]) begin
          ent_t e;
          e.pc   = in_pc[i*32 +: 32];
          e.insn = in_insn[i*32 +: 32];
          e.pt   = in_pred_taken[i];
          e.pa   = e.pt ? in_pred_target[i*32 +: 32] : e.pc + 32'd4;
          pend.push_back(e);
          if (e.pt) begin
            pend_taken = 1'b1;
            pend_tgt   = e.pa;
            break;
          end
        end
      end
    end
  endtask

  task automatic drive(input bit r, input bit f, input bit v, input logic [3:0] mask,
                       input logic [31:0] base, input logic [3:0] tk,
                       input logic [127:0] tg, input logic [1:0] take);
    @(posedge clk);
    foreach (pend[i]) sb.push_back(pend[i]);
    exp_rv  = pend_taken;
    exp_rpc = pend_tgt;
    #1;
    rst            = r;
    flush          = f;
    in_valid       = v;
    in_lane_valid  = mask;
    in_pc          = {base + 32'd12, base + 32'd8, base + 32'd4, base};
    in_insn        = {$urandom, $urandom, $urandom, $urandom};
    in_pred_taken  = tk;
    in_pred_target = tg;
    out_take       = take;
    predict();
  endtask

  task automatic idle(input logic [1:0] take);
    drive(1'b1, 1'b0, 1'b0, 4'b0000, 32'd0, 4'b0000, 128'd0, take);
  endtask

  // Monitor: compare head view against the scoreboard, then retire what is consumed.
  initial begin
    int  nvis;
    int  nout;
    bit  ready_m;
    forever begin
      @(negedge clk);
      nvis    = (sb.size() < DW) ? sb.size() : DW;
      ready_m = (QD - sb.size()) >= FW;
      if (chk_en) begin
        for (int k = 0; k < DW; k++) begin
          if (k < nvis) begin
            chk("out_valid", {31'd0, out_valid[k]}, 32'd1);
            chk("out_pc", out_pc[k*32 +: 32], sb[k].pc);
            chk("out_insn", out_insn[k*32 +: 32], sb[k].insn);
            chk("out_pred_taken", {31'd0, out_pred_taken[k]}, {31'd0, sb[k].pt});
            chk("out_pred_addr", out_pred_addr[k*32 +: 32], sb[k].pa);
          end else begin
            chk("out_valid_idle", {31'd0, out_valid[k]}, 32'd0);
            chk("out_fields_idle", out_pc[k*32 +: 32] | out_pred_addr[k*32 +: 32] | out_insn[k*32 +: 32]
                                   | {31'd0, out_pred_taken[k]}, 32'd0);
          end
        end
        chk("count", {28'd0, count}, sb.size());
        chk("in_ready", {31'd0, in_ready}, {31'd0, ready_m});
        chk("perf_stall_begin", {31'd0, perf_stall_begin}, {31'd0, in_valid & ~ready_m & ~stall_m});
        chk("redirect_valid", {31'd0, redirect_valid}, {31'd0, exp_rv});
        if (exp_rv) chk("redirect_pc", redirect_pc, exp_rpc);
      end
      if (!rst) begin
        sb.delete();
        stall_m = 1'b0;
        chk_en  = 1'b1;
      end else if (flush) begin
        sb.delete();
        stall_m = 1'b0;
      end else begin
        nout = (int'(out_take) < nvis) ? int'(out_take) : nvis;
        repeat (nout) void'(sb.pop_front());
        stall_m = in_valid & ~ready_m;
      end
    end
  end

  initial begin
    logic [3:0]   tk;
    logic [127:0] tg;
    rst = 1'b0; flush = 1'b0; in_valid = 1'b1; in_lane_valid = 4'b1111;
    in_pc = 128'd0; in_insn = 128'd0; in_pred_taken = 4'b0000;
    in_pred_target = 128'd0; out_take = 2'd0;
    drive(1'b0, 1'b0, 1'b1, 4'b1111, 32'h0, 4'b0000, 128'd0, 2'd0);
    idle(2'd0);
    chk("reset_count", {28'd0, count}, 32'd0);
    chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
    chk("reset_out_valid", {30'd0, out_valid}, 32'd0);

    // Straight-line group.
    drive(1'b1, 1'b0, 1'b1, 4'b1111, 32'h100, 4'b0000, 128'd0, 2'd0);
    idle(2'd0);
    chk("line_count", {28'd0, count}, 32'd4);
    chk("line_pc0", out_pc[31:0], 32'h100);
    chk("line_pc1", out_pc[63:32], 32'h104);
    chk("line_pa0", out_pred_addr[31:0], 32'h104);
    chk("line_pa1", out_pred_addr[63:32], 32'h108);
    drive(1'b1, 1'b1, 1'b0, 4'b0000, 32'h0, 4'b0000, 128'd0, 2'd0);

    // Taken branch in lane 1 squashes lanes 2 and 3.
    drive(1'b1, 1'b0, 1'b1, 4'b1111, 32'h100, 4'b0010, {64'd0, 32'h200, 32'd0}, 2'd0);
    idle(2'd0);
    chk("taken_count", {28'd0, count}, 32'd2);
    chk("taken_redirect_v", {31'd0, redirect_valid}, 32'd1);
    chk("taken_redirect_pc", redirect_pc, 32'h200);
    idle(2'd0);
    chk("taken_redirect_pulse", {31'd0, redirect_valid}, 32'd0);
    drive(1'b1, 1'b1, 1'b0, 4'b0000, 32'h0, 4'b0000, 128'd0, 2'd0);

    // Sparse lanes compact to the front.
    drive(1'b1, 1'b0, 1'b1, 4'b1010, 32'h100, 4'b0000, 128'd0, 2'd0);
    idle(2'd0);
    chk("sparse_count", {28'd0, count}, 32'd2);
    chk("sparse_pc0", out_pc[31:0], 32'h104);
    chk("sparse_pc1", out_pc[63:32], 32'h10C);
    drive(1'b1, 1'b1, 1'b0, 4'b0000, 32'h0, 4'b0000, 128'd0, 2'd0);

    // Back-pressure at count=6 with a pop in flight.
    drive(1'b1, 1'b0, 1'b1, 4'b1111, 32'h300, 4'b0000, 128'd0, 2'd0);
    drive(1'b1, 1'b0, 1'b1, 4'b1111, 32'h310, 4'b0000, 128'd0, 2'd2);
    drive(1'b1, 1'b0, 1'b1, 4'b1111, 32'h320, 4'b0000, 128'd0, 2'd2);
    chk("bp_count", {28'd0, count}, 32'd6);
    chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
    chk("bp_stall_begin", {31'd0, perf_stall_begin}, 32'd1);
    drive(1'b1, 1'b0, 1'b1, 4'b1111, 32'h330, 4'b0000, 128'd0, 2'd0);
    chk("bp_count_after", {28'd0, count}, 32'd4);
    chk("bp_ready_after", {31'd0, in_ready}, 32'd1);
    idle(2'd0);
    chk("bp_full", {28'd0, count}, 32'd8);
    repeat (4) idle(2'd3);

    // Flush with a group and a take pending.
    drive(1'b1, 1'b0, 1'b1, 4'b1111, 32'h400, 4'b0000, 128'd0, 2'd0);
    drive(1'b1, 1'b0, 1'b1, 4'b0001, 32'h500, 4'b0000, 128'd0, 2'd0);
    drive(1'b1, 1'b1, 1'b1, 4'b1111, 32'h600, 4'b0000, 128'd0, 2'd2);
    chk("flush_pre_count", {28'd0, count}, 32'd5);
    idle(2'd0);
    chk("flush_count", {28'd0, count}, 32'd0);
    chk("flush_out_valid", {30'd0, out_valid}, 32'd0);

    // Randomized traffic: wraps pointers, exercises clipping, flush and reset.
    for (int n = 0; n < 800; n++) begin
      for (int i = 0; i < FW; i++) tk[i] = ($urandom_range(0, 5) == 0);
      tg = {$urandom, $urandom, $urandom, $urandom};
      drive($urandom_range(0, 149) != 0, $urandom_range(0, 39) == 0, $urandom_range(0, 3) != 0,
            4'($urandom), $urandom & 32'hFFFF_FFFC, tk, tg, 2'($urandom_range(0, 3)));
    end
    repeat (6) idle(2'd3);
    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
